// File: rtl/ff_bank_if.sv
// ff_bank_if: control inputs and registered outputs of the ff_bank
// flip-flop bank, bundled so that the producer and the bank share one
// declaration.
interface ff_bank_if #(
   parameter int WIDTH     = 8,
   parameter int ERR_CNT_W = 8
);

   logic                 en;
   logic [1:0]           mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 clr_err;

   logic [WIDTH-1:0]     q;
   logic [WIDTH-1:0]     qb;
   logic [WIDTH-1:0]     chg;
   logic                 err;
   logic                 err_sticky;
   logic [ERR_CNT_W-1:0] err_cnt;

   // Driving side: whoever issues the per-cycle update commands
   modport master (
      output en, mode, a, b, clr_err,
      input  q, qb, chg, err, err_sticky, err_cnt
   );

   // The flip-flop bank itself
   modport slave (
      input  en, mode, a, b, clr_err,
      output q, qb, chg, err, err_sticky, err_cnt
   );

endinterface

// File: rtl/ff_bank.sv
// ff_bank: WIDTH flip-flops on one clock whose update rule (SR, JK, D or T)
// is chosen every cycle. q/qb/chg/err are all registered, so there is no
// combinational path from the inputs to any output. SR-mode cycles with
// S=R=1 on any bit are counted as illegal events, even when SR_BOTH gives
// them a defined resolution.
module ff_bank #(
   parameter int WIDTH     = 8,
   parameter int SR_BOTH   = 0,
   parameter int ERR_CNT_W = 8
) (
   input logic      clk,
   input logic      rst,
   ff_bank_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_SR = 2'd0,
      MODE_JK = 2'd1,
      MODE_D  = 2'd2,
      MODE_T  = 2'd3
   } mode_e;

   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   logic [WIDTH-1:0]     state_q,     state_d;
   logic [WIDTH-1:0]     chg_q,       chg_d;
   logic                 errPulse_q,  errPulse_d;
   logic                 errSticky_q, errSticky_d;
   logic [ERR_CNT_W-1:0] errCnt_q,    errCnt_d;
   logic                 illegalEvt;
   mode_e                curMode;

   assign curMode = mode_e'(bus.mode);

   // Per-bit next state for the selected mode; holding is the default so
   // en=0 and the "00" input combinations fall out naturally
   always_comb begin
      state_d = state_q;
      if (bus.en) begin
         for (int i = 0; i < WIDTH; i++) begin
            unique case (curMode)
               MODE_SR: begin
                  unique case ({bus.a[i], bus.b[i]})
                     2'b00: state_d[i] = state_q[i];
                     2'b01: state_d[i] = 1'b0;
                     2'b10: state_d[i] = 1'b1;
                     default: begin
                        case (SR_BOTH)
                           0:       state_d[i] = state_q[i];
                           1:       state_d[i] = 1'b1;
                           2:       state_d[i] = 1'b0;
                           default: state_d[i] = ~state_q[i];
                        endcase
                     end
                  endcase
               end
               MODE_JK: begin
                  unique case ({bus.a[i], bus.b[i]})
                     2'b00:   state_d[i] = state_q[i];
                     2'b01:   state_d[i] = 1'b0;
                     2'b10:   state_d[i] = 1'b1;
                     default: state_d[i] = ~state_q[i];
                  endcase
               end
               MODE_D:  state_d[i] = bus.a[i];
               default: state_d[i] = state_q[i] ^ bus.a[i];
            endcase
         end
      end
   end

   // One illegal event per cycle no matter how many bits have S=R=1
   always_comb begin
      illegalEvt = bus.en && (curMode == MODE_SR) && (|(bus.a & bus.b));
   end

   // Change pulses and error bookkeeping; a new event beats clr_err so a
   // clear racing an event leaves the count at exactly one
   always_comb begin
      chg_d       = state_d ^ state_q;
      errPulse_d  = illegalEvt;
      errSticky_d = errSticky_q;
      errCnt_d    = errCnt_q;
      if (bus.clr_err) begin
         errSticky_d = 1'b0;
         errCnt_d    = '0;
      end
      if (illegalEvt) begin
         errSticky_d = 1'b1;
         if (bus.clr_err) begin
            errCnt_d = CNT_ONE;
         end else if (errCnt_q != CNT_MAX) begin
            errCnt_d = errCnt_q + CNT_ONE;
         end
      end
   end

   // State register; reset discards whatever the inputs asked for this edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= '0;
         chg_q       <= '0;
         errPulse_q  <= 1'b0;
         errSticky_q <= 1'b0;
         errCnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         chg_q       <= chg_d;
         errPulse_q  <= errPulse_d;
         errSticky_q <= errSticky_d;
         errCnt_q    <= errCnt_d;
      end
   end

   // qb comes straight off the q register so the pair can never agree
   assign bus.q          = state_q;
   assign bus.qb         = ~state_q;
   assign bus.chg        = chg_q;
   assign bus.err        = errPulse_q;
   assign bus.err_sticky = errSticky_q;
   assign bus.err_cnt    = errCnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: drives four ff_bank instances (one per SR_BOTH setting, small
// 2-bit error counter) with identical stimulus. A vector-level reference
// model predicts each cycle's outputs into a queue; a monitor pops and
// compares after every rising edge.
module tb_ff_bank;

   localparam int W  = 8;
   localparam int CW = 2;
   localparam int ND = 4;

   typedef struct {
      logic [7:0] q   [ND];
      logic [7:0] chg [ND];
      logic       err [ND];
      logic       stk [ND];
      logic [1:0] cnt [ND];
   } expect_t;

   logic          clk;
   logic          rst;
   logic          en;
   logic [1:0]    mode;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          clrErr;

   logic [W-1:0]  qObs   [ND];
   logic [W-1:0]  qbObs  [ND];
   logic [W-1:0]  chgObs [ND];
   logic          errObs [ND];
   logic          stkObs [ND];
   logic [CW-1:0] cntObs [ND];

   expect_t       sbQ [$];
   int            nVectors;
   int            nMiscompares;
   bit            stimDone;

   logic [7:0]    mQ   [ND];
   int            mCnt [ND];
   logic          mStk [ND];

   for (genvar g = 0; g < ND; g++) begin : gDut
      ff_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) busG ();
      assign busG.en      = en;
      assign busG.mode    = mode;
      assign busG.a       = a;
      assign busG.b       = b;
      assign busG.clr_err = clrErr;
      assign qObs[g]      = busG.q;
      assign qbObs[g]     = busG.qb;
      assign chgObs[g]    = busG.chg;
      assign errObs[g]    = busG.err;
      assign stkObs[g]    = busG.err_sticky;
      assign cntObs[g]    = busG.err_cnt;
      ff_bank #(.WIDTH(W), .SR_BOTH(g), .ERR_CNT_W(CW)) dut (
         .clk(clk),
         .rst(rst),
         .bus(busG)
      );
   end

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so a broken design can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int g,
                              input logic [7:0] act, input logic [7:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s dut%0d got %h want %h", name, g, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue what the
   // bank should show after the next rising edge
   task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                input logic [7:0] av, input logic [7:0] bv,
                                input logic c);
      expect_t    ex;
      logic [7:0] nq;
      logic [7:0] both;
      logic [7:0] keep;
      logic [7:0] res;
      logic       ill;
      @(negedge clk);
      rst = r; en = e; mode = m; a = av; b = bv; clrErr = c;
      both = av & bv;
      keep = mQ[0];
      ill  = e && (m == 2'd0) && (both != 8'h00);
      for (int g = 0; g < ND; g++) begin
         if (r) begin
            mQ[g] = 8'h00; mCnt[g] = 0; mStk[g] = 1'b0;
            ex.q[g] = 8'h00; ex.chg[g] = 8'h00; ex.err[g] = 1'b0;
         end else begin
            nq   = mQ[g];
            keep = mQ[g] & ~(av | bv);
            if (e) begin
               case (m)
                  2'd0: begin
                     case (g)
                        0:       res = mQ[g] & both;
                        1:       res = both;
                        2:       res = 8'h00;
                        default: res = ~mQ[g] & both;
                     endcase
                     nq = keep | (av & ~bv) | res;
                  end
                  2'd1:    nq = keep | (av & ~bv) | (~mQ[g] & both);
                  2'd2:    nq = av;
                  default: nq = mQ[g] ^ av;
               endcase
            end
            ex.chg[g] = nq ^ mQ[g];
            ex.q[g]   = nq;
            ex.err[g] = ill;
            mQ[g]     = nq;
            if (ill) begin
               mCnt[g] = c ? 1 : ((mCnt[g] + 1 > 3) ? 3 : mCnt[g] + 1);
               mStk[g] = 1'b1;
            end else if (c) begin
               mCnt[g] = 0;
               mStk[g] = 1'b0;
            end
         end
         ex.stk[g] = mStk[g];
         ex.cnt[g] = 2'(mCnt[g]);
      end
      sbQ.push_back(ex);
   endtask

   // Monitor: one expected entry per rising edge, compared 1 time unit later
   initial begin
      expect_t ex;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            ex = sbQ.pop_front();
            for (int g = 0; g < ND; g++) begin
               checkOutput("q",       g, qObs[g],            ex.q[g]);
               checkOutput("qb",      g, qbObs[g],           ~ex.q[g]);
               checkOutput("chg",     g, chgObs[g],          ex.chg[g]);
               checkOutput("err",     g, {7'd0, errObs[g]},  {7'd0, ex.err[g]});
               checkOutput("sticky",  g, {7'd0, stkObs[g]},  {7'd0, ex.stk[g]});
               checkOutput("err_cnt", g, {6'd0, cntObs[g]},  {6'd0, ex.cnt[g]});
            end
         end
      end
   end

   // Directed scenarios followed by a randomized soak
   initial begin
      nVectors = 0; nMiscompares = 0; stimDone = 1'b0;
      rst = 1'b1; en = 1'b0; mode = 2'd0; a = '0; b = '0; clrErr = 1'b0;
      for (int g = 0; g < ND; g++) begin
         mQ[g] = 8'h00; mCnt[g] = 0; mStk[g] = 1'b0;
      end

      applyStimulus(1, 0, 2'd0, 8'h00, 8'h00, 0);
      applyStimulus(1, 0, 2'd0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 2'd0, 8'h0F, 8'hF0, 0);
      applyStimulus(0, 1, 2'd0, 8'h01, 8'h01, 0);
      applyStimulus(0, 1, 2'd2, 8'hA5, 8'h00, 0);
      applyStimulus(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
      applyStimulus(0, 1, 2'd3, 8'h0F, 8'h00, 0);
      applyStimulus(0, 1, 2'd2, 8'h3C, 8'hFF, 0);
      applyStimulus(0, 0, 2'd2, 8'hFF, 8'h00, 0);
      applyStimulus(1, 1, 2'd2, 8'hFF, 8'h00, 0);
      for (int k = 0; k < 5; k++) applyStimulus(0, 1, 2'd0, 8'hFF, 8'hFF, 0);
      applyStimulus(0, 1, 2'd2, 8'h00, 8'h00, 1);
      applyStimulus(0, 1, 2'd0, 8'h10, 8'h10, 1);
      applyStimulus(0, 0, 2'd0, 8'h10, 8'h10, 0);

      for (int k = 0; k < 400; k++) begin
         applyStimulus(($urandom_range(31) == 0),
                       ($urandom_range(3) != 0),
                       2'($urandom_range(3)),
                       8'($urandom), 8'($urandom),
                       ($urandom_range(7) == 0));
      end
      applyStimulus(0, 0, 2'd0, 8'h00, 8'h00, 0);
      stimDone = 1'b1;

      repeat (3) @(posedge clk);
      #2;
      if (sbQ.size() != 0) begin
         nMiscompares++;
         $display("[TB] FAIL drain got %0d pending want 0", sbQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
